// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive-side buffer.
// Imported by the FIFO interface, storage array and top-level control.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer bus of the UART receive FIFO.
// The almost_full signal exists only when UART_FIFO_ALMOST_FULL_EN is defined.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              clear;
  logic              enable;
  logic [DATA_W-1:0] byte_in;
  logic [DATA_W-1:0] byte_out;
  logic              ready;
  logic              rd_ack;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
`ifdef UART_FIFO_ALMOST_FULL_EN
  logic              almost_full;
`endif

  // Master is the byte receiver plus consumer; slave is the FIFO itself.
  modport master (
    output clear, enable, byte_in, rd_ack,
    input  byte_out, ready, full, empty, count, overflow
`ifdef UART_FIFO_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  clear, enable, byte_in, rd_ack,
    output byte_out, ready, full, empty, count, overflow
`ifdef UART_FIFO_ALMOST_FULL_EN
    , output almost_full
`endif
  );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow and sync flush.
// Define UART_FIFO_ALMOST_FULL_EN to add the registered almost_full flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16
`ifdef UART_FIFO_ALMOST_FULL_EN
  , parameter int AF_LVL = 12
`endif
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rdata;
  logic              empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write.
  assign pop  = !empty && bus.rd_ack;
  assign push = bus.enable && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.enable && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !bus.clear),
    .waddr (wr_ptr_q),
    .wdata (bus.byte_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.byte_out = empty ? '0 : rdata;
  assign bus.ready    = !empty;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef UART_FIFO_ALMOST_FULL_EN
  logic almost_full_q, almost_full_d;

  // Derived from the next count so the flag moves on the same edge as count.
  always_comb begin
    almost_full_d = (count_d >= CW'(AF_LVL));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) almost_full_q <= 1'b0;
    else        almost_full_q <= almost_full_d;
  end

  assign bus.almost_full = almost_full_q;
`endif

endmodule : uart_rx_fifo
